// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encoding and data width for the alu block
package alu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    OP_INC  = 4'd0,
    OP_DEC  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_MOV  = 4'd4,
    OP_NOT  = 4'd5,
    OP_OR   = 4'd6,
    OP_AND  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SETC = 4'd10,
    OP_CLC  = 4'd11
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - logical barrel shifter producing both directions and the last bit shifted out
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [3:0]        shamt,
  output logic [DATA_W-1:0] shl_result,
  output logic              shl_carry,
  output logic [DATA_W-1:0] shr_result,
  output logic              shr_carry
);

  logic [DATA_W:0] shl_ext;
  logic [DATA_W:0] shr_ext;

  // One guard bit on the outgoing side catches the last bit shifted out.
  assign shl_ext    = {1'b0, a} << shamt;
  assign shr_ext    = {a, 1'b0} >> shamt;

  assign shl_result = shl_ext[DATA_W-1:0];
  assign shl_carry  = shl_ext[DATA_W];
  assign shr_result = shr_ext[DATA_W:1];
  assign shr_carry  = shr_ext[0];

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 16-bit ALU with registered result and carry/negative/zero flags
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              ALU_EN,
  input  logic [3:0]        Function_Control,
  input  logic [3:0]        shiftamount,
  output logic [DATA_W-1:0] ALU_Out,
  output logic              CarryOut,
  output logic              NegativeFlag,
  output logic              ZeroFlag
);

  localparam logic [DATA_W:0] ONE_EXT = (DATA_W+1)'(1);

  alu_op_e           op;
  logic [DATA_W:0]   ext;
  logic [DATA_W-1:0] nxt_out;
  logic              nxt_c;
  logic              nxt_n;
  logic              nxt_z;
  logic              upd_nz;
  logic [DATA_W-1:0] shl_result;
  logic [DATA_W-1:0] shr_result;
  logic              shl_carry;
  logic              shr_carry;

  assign op = alu_op_e'(Function_Control);

  alu_shifter u_shifter (
    .a          (A),
    .shamt      (shiftamount),
    .shl_result (shl_result),
    .shl_carry  (shl_carry),
    .shr_result (shr_result),
    .shr_carry  (shr_carry)
  );

  always_comb begin
    nxt_out = ALU_Out;
    nxt_c   = CarryOut;
    upd_nz  = 1'b1;
    ext     = '0;
    // Arithmetic runs one bit wide so bit DATA_W is the carry, or the borrow for subtraction.
    case (op)
      OP_INC: begin ext = {1'b0, B} + ONE_EXT;  nxt_out = ext[DATA_W-1:0]; nxt_c = ext[DATA_W]; end
      OP_DEC: begin ext = {1'b0, B} - ONE_EXT;  nxt_out = ext[DATA_W-1:0]; nxt_c = ext[DATA_W]; end
      OP_ADD: begin ext = {1'b0, A} + {1'b0, B}; nxt_out = ext[DATA_W-1:0]; nxt_c = ext[DATA_W]; end
      OP_SUB: begin ext = {1'b0, A} - {1'b0, B}; nxt_out = ext[DATA_W-1:0]; nxt_c = ext[DATA_W]; end
      OP_MOV: nxt_out = B;
      OP_NOT: nxt_out = ~B;
      OP_OR:  nxt_out = A | B;
      OP_AND: nxt_out = A & B;
      OP_SHL: begin
        nxt_out = shl_result;
        if (shiftamount != 4'd0) nxt_c = shl_carry;
      end
      OP_SHR: begin
        nxt_out = shr_result;
        if (shiftamount != 4'd0) nxt_c = shr_carry;
      end
      OP_SETC: begin nxt_c = 1'b1; upd_nz = 1'b0; end
      OP_CLC:  begin nxt_c = 1'b0; upd_nz = 1'b0; end
      default: upd_nz = 1'b0;
    endcase
    nxt_n = upd_nz ? nxt_out[DATA_W-1] : NegativeFlag;
    nxt_z = upd_nz ? (nxt_out == '0)   : ZeroFlag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_Out      <= '0;
      CarryOut     <= 1'b0;
      NegativeFlag <= 1'b0;
      ZeroFlag     <= 1'b0;
    end else if (ALU_EN) begin
      ALU_Out      <= nxt_out;
      CarryOut     <= nxt_c;
      NegativeFlag <= nxt_n;
      ZeroFlag     <= nxt_z;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - randomized self-checking bench for alu against an arithmetic reference model
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        ALU_EN;
  logic [3:0]  Function_Control;
  logic [3:0]  shiftamount;
  logic [15:0] ALU_Out;
  logic        CarryOut;
  logic        NegativeFlag;
  logic        ZeroFlag;

  int checks;
  int failures;
  int m_out, m_c, m_n, m_z;

  alu dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .A                (A),
    .B                (B),
    .ALU_EN           (ALU_EN),
    .Function_Control (Function_Control),
    .shiftamount      (shiftamount),
    .ALU_Out          (ALU_Out),
    .CarryOut         (CarryOut),
    .NegativeFlag     (NegativeFlag),
    .ZeroFlag         (ZeroFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_out"}, int'(ALU_Out), m_out);
    check({tag, "_c"}, int'(CarryOut), m_c);
    check({tag, "_n"}, int'(NegativeFlag), m_n);
    check({tag, "_z"}, int'(ZeroFlag), m_z);
  endtask

  task automatic model_reset();
    m_out = 0; m_c = 0; m_n = 0; m_z = 0;
  endtask

  // Reference behaviour straight from the opcode table, in unbounded integer arithmetic.
  task automatic model_op(input int op, input int a, input int b, input int sh);
    int r;
    r = m_out;
    case (op)
      0: begin r = b + 1; m_c = (r > 65535) ? 1 : 0; end
      1: begin r = b - 1; m_c = (b < 1) ? 1 : 0; end
      2: begin r = a + b; m_c = (r > 65535) ? 1 : 0; end
      3: begin r = a - b; m_c = (b > a) ? 1 : 0; end
      4: r = b;
      5: r = 65535 - b;
      6: r = a | b;
      7: r = a & b;
      8: begin
        r = a * (1 << sh);
        if (sh != 0) m_c = (a >> (16 - sh)) & 1;
      end
      9: begin
        r = a / (1 << sh);
        if (sh != 0) m_c = (a >> (sh - 1)) & 1;
      end
      10: m_c = 1;
      11: m_c = 0;
      default: ;
    endcase
    if (op <= 9) begin
      m_out = r & 16'hFFFF;
      m_n   = (m_out >= 32768) ? 1 : 0;
      m_z   = (m_out == 0) ? 1 : 0;
    end
  endtask

  task automatic step(input string tag, input logic en, input logic [3:0] op,
                      input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh);
    @(negedge clk);
    ALU_EN = en; Function_Control = op; A = a; B = b; shiftamount = sh;
    @(posedge clk);
    #1;
    if (en) model_op(int'(op), int'(a), int'(b), int'(sh));
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1; ALU_EN = 1'b0; Function_Control = 4'd0;
    A = 16'h0; B = 16'h0; shiftamount = 4'd0;
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_all("reset");
    ALU_EN = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    step("sub", 1'b1, 4'd3, 16'd10, 16'd20, 4'd0);
    check("sub_const", int'(ALU_Out), 16'hFFF6);
    check("sub_c_const", int'(CarryOut), 1);
    step("inc_wrap", 1'b1, 4'd0, 16'h1234, 16'hFFFF, 4'd0);
    check("inc_z_const", int'(ZeroFlag), 1);
    step("dec_zero", 1'b1, 4'd1, 16'h0, 16'h0, 4'd0);
    check("dec_const", int'(ALU_Out), 16'hFFFF);
    step("add", 1'b1, 4'd2, 16'd20, 16'd20, 4'd0);
    check("add_const", int'(ALU_Out), 16'h0028);
    step("setc0", 1'b1, 4'd10, 16'h0, 16'h0, 4'd0);
    step("or", 1'b1, 4'd6, 16'h5555, 16'hAAAA, 4'd0);
    check("or_const", int'(ALU_Out), 16'hFFFF);
    step("and", 1'b1, 4'd7, 16'h5555, 16'hAAAA, 4'd0);
    check("and_c_kept", int'(CarryOut), 1);
    step("shl", 1'b1, 4'd8, 16'hFFF8, 16'h0, 4'd2);
    check("shl_const", int'(ALU_Out), 16'hFFE0);
    step("shr", 1'b1, 4'd9, 16'hFFF8, 16'h0, 4'd2);
    check("shr_const", int'(ALU_Out), 16'h3FFE);
    step("shl_sh0", 1'b1, 4'd8, 16'h8001, 16'h0, 4'd0);
    step("shr_sh15", 1'b1, 4'd9, 16'h8001, 16'h0, 4'd15);
    step("setc", 1'b1, 4'd10, 16'h1111, 16'h2222, 4'd3);
    check("setc_out_held", int'(ALU_Out), 1);
    step("clc", 1'b1, 4'd11, 16'h1111, 16'h2222, 4'd3);
    step("nop", 1'b1, 4'd13, 16'hFFFF, 16'hFFFF, 4'd7);
    step("disabled", 1'b0, 4'd0, 16'h0, 16'hFFFF, 4'd0);

    // Input changes between edges must not reach the registered outputs.
    A = 16'hBEEF; B = 16'h0; Function_Control = 4'd4; ALU_EN = 1'b1;
    #2;
    check_all("no_edge");

    step("pre_reset", 1'b1, 4'd5, 16'h0, 16'h00F0, 4'd0);
    pulse_reset("mid_reset");

    for (int i = 0; i < 600; i++) begin
      logic [3:0] sh;
      sh = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step("rand", $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           16'($urandom), 16'($urandom), sh);
      if (i % 150 == 149) pulse_reset("rand_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
